// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment display blocks.
//   SEG_BLANK     - all segments off (segments are active-low)
//   digit_entry_t - one stored digit: hex value, decimal point, blank flag
//   ENTRY_RESET   - value 0, dp off, blanked
//   hex_to_seg    - nibble to active-low segments, bit [6]=a ... [0]=g
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic [3:0] value;
    logic       dp;
    logic       blank;
  } digit_entry_t;

  localparam digit_entry_t ENTRY_RESET = '{value: 4'h0, dp: 1'b0, blank: 1'b1};

  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: user-side write port of the display controller.
//   clear    - synchronous clear of all digit storage
//   wr_en    - write strobe, one cycle per write
//   wr_addr  - digit index, 0 = rightmost
//   wr_data  - hex value
//   wr_dp    - decimal point on
//   wr_blank - digit blanked
//   blink_en - per-digit blink enable, level
// Handshake: there is no ready. wr_en is a one-cycle strobe that is always
// accepted on the edge where it is high; holding it high for N cycles is N
// writes. clear takes priority over a write in the same cycle.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  localparam int AW = $clog2(NUM_DIGITS);

  logic                  clear;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [3:0]            wr_data;
  logic                  wr_dp;
  logic                  wr_blank;
  logic [NUM_DIGITS-1:0] blink_en;

  modport master (
    output clear, wr_en, wr_addr, wr_data, wr_dp, wr_blank, blink_en
  );

  modport slave (
    input clear, wr_en, wr_addr, wr_data, wr_dp, wr_blank, blink_en
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to active-low segment decoder.
//   value - 4-bit hex digit
//   seg   - segments, [6]=a ... [0]=g, 0 = lit
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);
  assign seg = hex_to_seg(value);
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed seven-segment display controller.
// Stores one {value, dp, blank} entry per digit and scans them onto shared
// active-low cathodes with one active-low anode per digit. Each slot starts
// with one dead cycle (all anodes off). A valid write forces the written
// digit onto the display for HOLD_SLOTS slot ticks.
//   clk      - single clock
//   reset    - synchronous, active-high
//   bus      - write port (seg7_scan_ctrl_if.slave)
//   anode    - active-low digit select, registered
//   cathodes - active-low segments [6]=a ... [0]=g, registered
//   dp       - active-low decimal point, registered
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_SLOTS = 512,
  parameter int HOLD_SLOTS  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  seg7_scan_ctrl_if.slave       bus,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            cathodes,
  output logic                  dp
);

  localparam int AW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
  localparam int HW = (HOLD_SLOTS > 0) ? $clog2(HOLD_SLOTS + 1) : 1;
  localparam logic [NUM_DIGITS-1:0] DIGIT0 = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  digit_entry_t  entries [NUM_DIGITS];
  logic [PW-1:0] prescaler;
  logic [AW-1:0] scan_idx;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic [HW-1:0] hold_cnt;
  logic [AW-1:0] hold_addr;

  logic          tick;
  logic          write_ok;
  logic [AW-1:0] disp_idx;
  digit_entry_t  entry;
  logic [6:0]    seg;
  logic          suppress;

  assign tick = (prescaler == PW'(REFRESH_DIV - 1));

  // Addresses past the last digit exist when NUM_DIGITS is not a power of two;
  // such writes are dropped entirely, including the hold they would start.
  assign write_ok = bus.wr_en && !bus.clear && (32'(bus.wr_addr) < NUM_DIGITS);

  assign disp_idx = (hold_cnt != '0) ? hold_addr : scan_idx;
  assign entry    = entries[disp_idx];
  assign suppress = entry.blank | (bus.blink_en[disp_idx] & ~phase);

  seg7_hex_decode u_decode (
    .value (entry.value),
    .seg   (seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      scan_idx  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b1;
      hold_cnt  <= '0;
      hold_addr <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) entries[i] <= ENTRY_RESET;
      anode     <= '1;
      cathodes  <= SEG_BLANK;
      dp        <= 1'b1;
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);

      if (tick) begin
        scan_idx <= (scan_idx == AW'(NUM_DIGITS - 1)) ? '0 : scan_idx + AW'(1);
        if (blink_cnt == BW'(BLINK_SLOTS - 1)) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end

      if (bus.clear) begin
        for (int i = 0; i < NUM_DIGITS; i++) entries[i] <= ENTRY_RESET;
      end else if (write_ok) begin
        entries[bus.wr_addr] <= '{value: bus.wr_data, dp: bus.wr_dp, blank: bus.wr_blank};
      end

      // A write landing on a tick reloads rather than decrements.
      if (write_ok) begin
        hold_cnt  <= HW'(HOLD_SLOTS);
        hold_addr <= bus.wr_addr;
      end else if (tick && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HW'(1);
      end

      // First cycle of every slot is dead time so the previous digit's
      // segments never ghost onto the next anode.
      anode    <= (prescaler == '0) ? '1 : ~(DIGIT0 << disp_idx);
      cathodes <= suppress ? SEG_BLANK : seg;
      dp       <= suppress | ~entry.dp;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst4;
  logic rst3;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  seg7_scan_ctrl_if #(.NUM_DIGITS(4)) bus4 ();
  seg7_scan_ctrl_if #(.NUM_DIGITS(3)) bus3 ();

  logic [3:0] anode4;
  logic [6:0] cath4;
  logic       dp4;
  logic [2:0] anode3;
  logic [6:0] cath3;
  logic       dp3;

  seg7_scan_ctrl #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLINK_SLOTS(2), .HOLD_SLOTS(3)
  ) dut4 (
    .clk      (clk),
    .reset    (rst4),
    .bus      (bus4),
    .anode    (anode4),
    .cathodes (cath4),
    .dp       (dp4)
  );

  seg7_scan_ctrl #(
    .NUM_DIGITS(3), .REFRESH_DIV(4), .BLINK_SLOTS(2), .HOLD_SLOTS(3)
  ) dut3 (
    .clk      (clk),
    .reset    (rst3),
    .bus      (bus3),
    .anode    (anode3),
    .cathodes (cath3),
    .dp       (dp3)
  );

  // ---------------- expected segment patterns ----------------
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SF = 7'b0111000;

  // ---------------- vector table ----------------
  // Inputs are held for n cycles; after each edge the outputs are compared.
  typedef struct {
    logic       rst;
    logic       clr;
    logic       we;
    logic [1:0] addr;
    logic [3:0] data;
    logic       wdp;
    logic       wbl;
    logic [3:0] blink;
    int         n;
    logic [3:0] exp_anode;
    logic [6:0] exp_cath;
    logic       exp_dp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, clr, we, input logic [1:0] addr,
                              input logic [3:0] data, input logic wdp, wbl,
                              input logic [3:0] blink, input int n,
                              input logic [3:0] an, input logic [6:0] ca,
                              input logic d);
    vec_t v;
    v.rst = rst;  v.clr = clr;  v.we = we;  v.addr = addr;  v.data = data;
    v.wdp = wdp;  v.wbl = wbl;  v.blink = blink;  v.n = n;
    v.exp_anode = an;  v.exp_cath = ca;  v.exp_dp = d;
    return v;
  endfunction

  function automatic vec_t idle(input logic [3:0] blink, input int n,
                                input logic [3:0] an, input logic [6:0] ca, input logic d);
    return mk(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, blink, n, an, ca, d);
  endfunction

  function automatic vec_t wr(input logic [3:0] blink, input logic clr, input logic [1:0] addr,
                              input logic [3:0] data, input logic wdp, wbl,
                              input logic [3:0] an, input logic [6:0] ca, input logic d);
    return mk(1'b0, clr, 1'b1, addr, data, wdp, wbl, blink, 1, an, ca, d);
  endfunction

  function automatic vec_t rst_row(input int n);
    return mk(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 4'b0000, n, 4'b1111, BL, 1'b1);
  endfunction

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int idx,
                       input logic [3:0] an, input logic [3:0] ea,
                       input logic [6:0] ca, input logic [6:0] eca,
                       input logic d, input logic ed);
    n_vec++;
    if (an !== ea || ca !== eca || d !== ed) begin
      n_err++;
      $display("FAIL %s #%0d: anode=%b cathodes=%b dp=%b, expected anode=%b cathodes=%b dp=%b",
               tag, idx, an, ca, d, ea, eca, ed);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive4(input vec_t v);
    rst4          = v.rst;
    bus4.clear    = v.clr;
    bus4.wr_en    = v.we;
    bus4.wr_addr  = v.addr;
    bus4.wr_data  = v.data;
    bus4.wr_dp    = v.wdp;
    bus4.wr_blank = v.wbl;
    bus4.blink_en = v.blink;
  endtask

  task automatic idle3();
    bus3.clear    = 1'b0;
    bus3.wr_en    = 1'b0;
    bus3.wr_addr  = 2'd0;
    bus3.wr_data  = 4'h0;
    bus3.wr_dp    = 1'b0;
    bus3.wr_blank = 1'b0;
    bus3.blink_en = 3'b000;
  endtask

  // ---------------- test ----------------
  initial begin
    int cyc;
    logic [2:0] e3;
    int p;
    int s;

    rst3 = 1'b1;
    idle3();

    // Reset values.
    vecs.push_back(rst_row(2));
    // Empty scan: dead cycle then three lit cycles per slot, all blank.
    vecs.push_back(idle(4'h0, 1, 4'b1111, BL, 1'b1));
    vecs.push_back(idle(4'h0, 3, 4'b1110, BL, 1'b1));
    vecs.push_back(idle(4'h0, 1, 4'b1111, BL, 1'b1));
    vecs.push_back(idle(4'h0, 3, 4'b1101, BL, 1'b1));
    vecs.push_back(idle(4'h0, 1, 4'b1111, BL, 1'b1));
    vecs.push_back(idle(4'h0, 3, 4'b1011, BL, 1'b1));
    vecs.push_back(idle(4'h0, 1, 4'b1111, BL, 1'b1));
    vecs.push_back(idle(4'h0, 3, 4'b0111, BL, 1'b1));
    // Digit 2 = 5 with dp, held for 3 ticks, then scan resumes.
    vecs.push_back(wr(4'h0, 1'b0, 2'd2, 4'h5, 1'b1, 1'b0, 4'b1111, BL, 1'b1));
    vecs.push_back(idle(4'h0, 3, 4'b1011, S5, 1'b0));
    vecs.push_back(idle(4'h0, 1, 4'b1111, S5, 1'b0));
    vecs.push_back(idle(4'h0, 3, 4'b1011, S5, 1'b0));
    vecs.push_back(idle(4'h0, 1, 4'b1111, S5, 1'b0));
    vecs.push_back(idle(4'h0, 3, 4'b1011, S5, 1'b0));
    vecs.push_back(idle(4'h0, 1, 4'b1111, BL, 1'b1));
    vecs.push_back(idle(4'h0, 3, 4'b0111, BL, 1'b1));
    vecs.push_back(idle(4'h0, 1, 4'b1111, BL, 1'b1));
    vecs.push_back(idle(4'h0, 3, 4'b1110, BL, 1'b1));
    vecs.push_back(idle(4'h0, 1, 4'b1111, BL, 1'b1));
    vecs.push_back(idle(4'h0, 3, 4'b1101, BL, 1'b1));
    vecs.push_back(idle(4'h0, 1, 4'b1111, S5, 1'b0));
    vecs.push_back(idle(4'h0, 3, 4'b1011, S5, 1'b0));
    // Back-to-back writes 0,9,A,F; last one lands on a tick and holds digit 3.
    vecs.push_back(wr(4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 4'b1111, BL, 1'b1));
    vecs.push_back(wr(4'h0, 1'b0, 2'd1, 4'h9, 1'b0, 1'b0, 4'b1110, S0, 1'b1));
    vecs.push_back(wr(4'h0, 1'b0, 2'd2, 4'hA, 1'b0, 1'b0, 4'b1101, S9, 1'b1));
    vecs.push_back(wr(4'h0, 1'b0, 2'd3, 4'hF, 1'b0, 1'b0, 4'b1011, SA, 1'b1));
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(idle(4'h0, 1, 4'b1111, SF, 1'b1));
      vecs.push_back(idle(4'h0, 3, 4'b0111, SF, 1'b1));
    end
    vecs.push_back(idle(4'h0, 1, 4'b1111, S0, 1'b1));
    vecs.push_back(idle(4'h0, 3, 4'b1110, S0, 1'b1));
    vecs.push_back(idle(4'h0, 1, 4'b1111, S9, 1'b1));
    vecs.push_back(idle(4'h0, 3, 4'b1101, S9, 1'b1));
    vecs.push_back(idle(4'h0, 1, 4'b1111, SA, 1'b1));
    vecs.push_back(idle(4'h0, 3, 4'b1011, SA, 1'b1));
    vecs.push_back(idle(4'h0, 1, 4'b1111, SF, 1'b1));
    vecs.push_back(idle(4'h0, 3, 4'b0111, SF, 1'b1));
    // Blink on digit 0 = 8, kept on screen by re-writing it during the hold.
    vecs.push_back(wr(4'h1, 1'b0, 2'd0, 4'h8, 1'b0, 1'b0, 4'b1111, S0, 1'b1));
    vecs.push_back(idle(4'h1, 3, 4'b1110, S8, 1'b1));
    vecs.push_back(idle(4'h1, 1, 4'b1111, S8, 1'b1));
    vecs.push_back(idle(4'h1, 3, 4'b1110, S8, 1'b1));
    vecs.push_back(wr(4'h1, 1'b0, 2'd0, 4'h8, 1'b0, 1'b0, 4'b1111, BL, 1'b1));
    vecs.push_back(idle(4'h1, 3, 4'b1110, BL, 1'b1));
    vecs.push_back(idle(4'h1, 1, 4'b1111, BL, 1'b1));
    vecs.push_back(idle(4'h1, 3, 4'b1110, BL, 1'b1));
    vecs.push_back(idle(4'h1, 1, 4'b1111, S8, 1'b1));
    vecs.push_back(idle(4'h1, 3, 4'b1110, S8, 1'b1));
    vecs.push_back(idle(4'h1, 1, 4'b1111, S9, 1'b1));
    vecs.push_back(idle(4'h1, 3, 4'b1101, S9, 1'b1));
    vecs.push_back(idle(4'h1, 1, 4'b1111, SA, 1'b1));
    vecs.push_back(idle(4'h1, 3, 4'b1011, SA, 1'b1));
    // clear together with a write: everything blank, no hold on digit 1.
    vecs.push_back(wr(4'h0, 1'b1, 2'd1, 4'h5, 1'b1, 1'b0, 4'b1111, SF, 1'b1));
    vecs.push_back(idle(4'h0, 3, 4'b0111, BL, 1'b1));
    vecs.push_back(idle(4'h0, 1, 4'b1111, BL, 1'b1));
    vecs.push_back(idle(4'h0, 3, 4'b1110, BL, 1'b1));
    // Write digit 1 = 7 with dp, then reset mid-slot and mid-hold.
    vecs.push_back(wr(4'h0, 1'b0, 2'd1, 4'h7, 1'b1, 1'b0, 4'b1111, BL, 1'b1));
    vecs.push_back(idle(4'h0, 1, 4'b1101, S7, 1'b0));
    vecs.push_back(rst_row(2));
    vecs.push_back(idle(4'h0, 1, 4'b1111, BL, 1'b1));
    vecs.push_back(idle(4'h0, 3, 4'b1110, BL, 1'b1));
    // Blanked digit with dp set: dp suppressed too; then unblank it.
    vecs.push_back(wr(4'h0, 1'b0, 2'd1, 4'h3, 1'b1, 1'b1, 4'b1111, BL, 1'b1));
    vecs.push_back(idle(4'h0, 3, 4'b1101, BL, 1'b1));
    vecs.push_back(wr(4'h0, 1'b0, 2'd1, 4'h3, 1'b1, 1'b0, 4'b1111, BL, 1'b1));
    vecs.push_back(idle(4'h0, 3, 4'b1101, S3, 1'b0));

    cyc = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive4(vecs[i]);
      for (int k = 0; k < vecs[i].n; k++) begin
        @(posedge clk);
        #1;
        cyc++;
        check("nd4_row", i, anode4, vecs[i].exp_anode, cath4, vecs[i].exp_cath,
              dp4, vecs[i].exp_dp);
      end
    end
    drive4(idle(4'h0, 1, 4'b1111, BL, 1'b1));

    // NUM_DIGITS=3: write to nonexistent address 3 must not store or hold.
    rst3 = 1'b1;
    @(posedge clk);
    #1;
    check("nd3_reset", 0, {1'b0, anode3}, 4'b0111, cath3, BL, dp3, 1'b1);
    rst3 = 1'b0;
    bus3.wr_en   = 1'b1;
    bus3.wr_addr = 2'd3;
    bus3.wr_data = 4'h5;
    bus3.wr_dp   = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      #1;
      bus3.wr_en = 1'b0;
      p = (k - 1) % 4;
      s = ((k - 1) / 4) % 3;
      e3 = (p == 0) ? 3'b111 : ~(3'b001 << s);
      check("nd3_scan", k, {1'b0, anode3}, {1'b0, e3}, cath3, BL, dp3, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
